// File: rtl/sm2ct_stream_pkg.sv
// ---------------------------------------------------------------------------
// sm2ct_stream_pkg
// Shared AES definitions for the state-matrix-to-ciphertext streamer.
//   state_t  : 4x4 AES state, row index first, column index second.
//   NB       : number of state columns (4).
//   BLOCK_BYTES : bytes per AES block (16).
//   fsm_t    : streamer FSM encoding.
//   flatten  : state -> 128-bit block, column-major, byte 0 in [127:120].
// ---------------------------------------------------------------------------
package sm2ct_stream_pkg;

  localparam int NB          = 4;
  localparam int BLOCK_BYTES = 16;

  typedef logic [0:3][0:3][7:0] state_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } fsm_t;

  // Bytes are shifted in from the right, so the first byte visited
  // (row 0, column 0) ends up in the most significant position.
  function automatic logic [127:0] flatten(input state_t s);
    logic [127:0] f;
    f = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < NB; r++) begin
        f = {f[119:0], s[2'(r)][2'(c)]};
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/sm2ct_stream_inv_shift_rows.sv
// ---------------------------------------------------------------------------
// invShiftRows
// Combinational AES InvShiftRows: row r is rotated right by r positions.
//   state_matrix   (in)  : 4x4 state, row index first.
//   shifted_matrix (out) : shifted[r][c] = state[r][(c - r) mod 4].
// ---------------------------------------------------------------------------
module invShiftRows
  import sm2ct_stream_pkg::*;
(
  input  state_t state_matrix,
  output state_t shifted_matrix
);

  for (genvar gi = 0; gi < NB; gi++) begin : g_row
    for (genvar gj = 0; gj < NB; gj++) begin : g_col
      assign shifted_matrix[gi][gj] = state_matrix[gi][(gj - gi + NB) % NB];
    end
  end

endmodule

// File: rtl/sm2ct_stream.sv
// ---------------------------------------------------------------------------
// sm2ct_stream
// Captures an AES state matrix (optionally undoing ShiftRows), holds it as a
// 128-bit ciphertext block and streams it out one byte per handshake in
// column-major order.
//   clk, rst      : clock, asynchronous active-high reset.
//   state_matrix  : input state, row index first.
//   in_valid/in_ready   : capture handshake.
//   out_byte/out_valid/out_ready/out_last : byte stream, out_last on byte 15.
//   ciphertext    : last captured block, byte 0 in [127:120].
//   busy          : bytes of a captured block remain unsent.
// Parameter INV_SHIFT: 1 applies InvShiftRows on capture, 0 passes through.
// ---------------------------------------------------------------------------
module sm2ct_stream
  import sm2ct_stream_pkg::*;
#(
  parameter int INV_SHIFT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  state_t       state_matrix,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [7:0]   out_byte,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic [127:0] ciphertext,
  output logic         busy
);

  fsm_t             state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [0:15][7:0] buf_reg;
  logic [127:0]     ct_reg;
  state_t           t_matrix;
  logic             in_xfer;
  logic             at_last;

  if (INV_SHIFT != 0) begin : g_inv
    invShiftRows u_inv (
      .state_matrix  (state_matrix),
      .shifted_matrix(t_matrix)
    );
  end else begin : g_pass
    assign t_matrix = state_matrix;
  end

  assign at_last = (cnt_reg == 4'(BLOCK_BYTES - 1));
  assign in_xfer = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = SEND;
          cnt_next   = '0;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        // A new block may only enter as the final byte leaves, which lets
        // consecutive blocks stream with no gap.
        in_ready  = out_ready & at_last;
        if (out_ready) begin
          // Counter wraps 15 -> 0, which is exactly the reload case.
          cnt_next = cnt_reg + 4'd1;
          if (at_last && !in_valid) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_reg <= '0;
      ct_reg  <= '0;
    end else if (in_xfer) begin
      buf_reg <= flatten(t_matrix);
      ct_reg  <= flatten(t_matrix);
    end
  end

  // Gate the byte with out_valid so nothing stale is visible while idle.
  assign out_byte   = out_valid ? buf_reg[cnt_reg] : 8'h00;
  assign out_last   = out_valid & at_last;
  assign ciphertext = ct_reg;
  assign busy       = (state_reg == SEND);

endmodule

// File: tb/tb_sm2ct_stream.sv
// ---------------------------------------------------------------------------
// tb_sm2ct_stream
// Directed bench for sm2ct_stream: one instance with InvShiftRows, one
// pass-through instance. Inputs change and outputs are sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_sm2ct_stream;
  import sm2ct_stream_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  state_t       state_matrix = '0;
  logic         out_ready = 1'b0;

  logic         in_valid1 = 1'b0;
  logic         in_ready1, out_valid1, out_last1, busy1;
  logic [7:0]   out_byte1;
  logic [127:0] ct1;

  logic         in_valid0 = 1'b0;
  logic         in_ready0, out_valid0, out_last0, busy0;
  logic [7:0]   out_byte0;
  logic [127:0] ct0;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] V1_PT  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] V1_EXP = 128'h00DDAA774411EEBB885522FFCC996633;
  localparam logic [127:0] V2_PT  = 128'h6BC1BEE22E409F96E93D7E117393172A;
  localparam logic [127:0] V3_PT  = 128'h3925841D02DC09FBDC118597196A0B32;

  always #5 clk = ~clk;

  sm2ct_stream #(.INV_SHIFT(1)) dut1 (
    .clk(clk), .rst(rst), .state_matrix(state_matrix),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .out_byte(out_byte1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_last(out_last1), .ciphertext(ct1), .busy(busy1)
  );

  sm2ct_stream #(.INV_SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .state_matrix(state_matrix),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .out_byte(out_byte0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_last(out_last0), .ciphertext(ct0), .busy(busy0)
  );

  function automatic logic [7:0] byte_of(input logic [127:0] v, input int i);
    logic [127:0] tmp;
    tmp = v >> (8 * (15 - i));
    return tmp[7:0];
  endfunction

  // Plaintext to state, column-major.
  function automatic state_t pt2sm(input logic [127:0] p);
    state_t s;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[2'(r)][2'(c)] = byte_of(p, 4 * c + r);
    return s;
  endfunction

  // Forward ShiftRows: row r rotated left by r.
  function automatic state_t shift_rows(input state_t s);
    state_t t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[2'(r)][2'(c)] = s[2'(r)][2'((c + r) % 4)];
    return t;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one block at the current falling edge; returns one cycle later.
  task automatic capture(input string tag, input state_t s, input bit d0);
    state_matrix = s;
    out_ready    = 1'b1;
    if (d0) begin
      chk({tag, " in_ready"}, in_ready0, 1'b1);
      in_valid0 = 1'b1;
    end else begin
      chk({tag, " in_ready"}, in_ready1, 1'b1);
      in_valid1 = 1'b1;
    end
    @(negedge clk);
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
  endtask

  // Receive 16 bytes with out_ready held high and check the whole block.
  task automatic drain(input string tag, input logic [127:0] exp, input bit d0);
    chk({tag, " ciphertext"}, d0 ? ct0 : ct1, exp);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s valid%0d", tag, i), d0 ? out_valid0 : out_valid1, 1'b1);
      chk($sformatf("%s byte%0d", tag, i), d0 ? out_byte0 : out_byte1, byte_of(exp, i));
      chk($sformatf("%s last%0d", tag, i), d0 ? out_last0 : out_last1, (i == 15));
      $display("%s: byte %0d = %02h", tag, i, d0 ? out_byte0 : out_byte1);
      @(negedge clk);
    end
    chk({tag, " idle valid"}, d0 ? out_valid0 : out_valid1, 1'b0);
    chk({tag, " idle busy"}, d0 ? busy0 : busy1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int delivered;

    // Reset state
    @(negedge clk);
    chk("rst out_valid", out_valid1, 1'b0);
    chk("rst out_last", out_last1, 1'b0);
    chk("rst out_byte", out_byte1, 8'h00);
    chk("rst busy", busy1, 1'b0);
    chk("rst ciphertext", ct1, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // V1: InvShiftRows, continuous out_ready
    capture("V1", pt2sm(V1_PT), 1'b0);
    chk("V1 busy", busy1, 1'b1);
    drain("V1", V1_EXP, 1'b0);

    // V2: ShiftRows then InvShiftRows round trip
    capture("V2", shift_rows(pt2sm(V2_PT)), 1'b0);
    drain("V2", V2_PT, 1'b0);

    // V3: pass-through instance
    capture("V3", pt2sm(V3_PT), 1'b1);
    drain("V3", V3_PT, 1'b1);

    // V4: out_ready toggles 0/1, 32 valid cycles, each byte once
    capture("V4", pt2sm(V1_PT), 1'b0);
    idx = 0;
    delivered = 0;
    for (int k = 0; k < 32; k++) begin
      out_ready = 1'(k % 2);
      chk($sformatf("V4 valid k%0d", k), out_valid1, 1'b1);
      chk($sformatf("V4 byte k%0d", k), out_byte1, byte_of(V1_EXP, idx));
      chk($sformatf("V4 last k%0d", k), out_last1, (idx == 15));
      if (out_valid1 && out_ready) begin
        delivered++;
        $display("V4: cycle %0d byte %0d = %02h", k, idx, out_byte1);
      end
      if (out_ready) idx++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("V4 delivered", 128'(delivered), 128'd16);
    chk("V4 idle valid", out_valid1, 1'b0);

    // V5: two blocks back-to-back, no bubble
    state_matrix = pt2sm(V1_PT);
    in_valid1    = 1'b1;
    out_ready    = 1'b1;
    @(negedge clk);
    state_matrix = shift_rows(pt2sm(V2_PT));
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("V5 valid%0d", i), out_valid1, 1'b1);
      chk($sformatf("V5 byte%0d", i), out_byte1,
          (i < 16) ? byte_of(V1_EXP, i) : byte_of(V2_PT, i - 16));
      chk($sformatf("V5 last%0d", i), out_last1, (i % 16 == 15));
      chk($sformatf("V5 in_ready%0d", i), in_ready1, (i % 16 == 15));
      if (i == 10) chk("V5 ct A held", ct1, V1_EXP);
      if (i == 16) begin
        chk("V5 ct B", ct1, V2_PT);
        in_valid1 = 1'b0;
      end
      $display("V5: cycle %0d byte = %02h", i, out_byte1);
      @(negedge clk);
    end
    chk("V5 idle valid", out_valid1, 1'b0);

    // V6: reset after byte 5, then a fresh block from byte 0
    capture("V6", pt2sm(V1_PT), 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("V6 byte%0d", i), out_byte1, byte_of(V1_EXP, i));
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("V6 rst out_valid", out_valid1, 1'b0);
    chk("V6 rst ciphertext", ct1, 128'h0);
    chk("V6 rst busy", busy1, 1'b0);
    chk("V6 rst out_byte", out_byte1, 8'h00);
    $display("V6: reset asserted mid-block");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("V6 post in_ready", in_ready1, 1'b1);
    chk("V6 post out_valid", out_valid1, 1'b0);
    capture("V6b", shift_rows(pt2sm(V2_PT)), 1'b0);
    drain("V6b", V2_PT, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
